// File: rtl/pd_speed_regulator.sv
// ============================================================================
// Module   : pd_speed_regulator
// Brief    : Sampled PD speed controller driving an edge-aligned PWM output.
//            Optional duty slew limiting is enabled by the PD_SLEW_LIMIT_EN macro.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pd_speed_regulator #(
    parameter int DUTY_W    = 8,
    parameter int SHIFT     = 2,
    parameter int SLEW_STEP = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sample_en,
    input  logic [9:0]        target_vel,
    input  logic [9:0]        current_vel,
    input  logic [3:0]        Kp,
    input  logic [3:0]        Kd,
    output logic              busy,
    output logic [DUTY_W-1:0] duty,
    output logic              duty_valid,
    output logic              sat_flag,
    output logic              pwm_out
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_MULT    = 2'd2,
        S_SUM     = 2'd3
    } state_t;

    localparam logic signed [17:0] c_duty_max = 18'(2 ** DUTY_W - 1);
    localparam logic [DUTY_W-1:0]  c_cnt_max  = {DUTY_W{1'b1}};

    state_t                    r_state;
    state_t                    w_state_next;
    logic                      w_busy;

    logic [9:0]                r_tgt;
    logic [9:0]                r_cur;
    logic [3:0]                r_kp;
    logic [3:0]                r_kd;
    logic signed [10:0]        r_e;
    logic signed [11:0]        r_de;
    logic signed [10:0]        r_prev;
    logic signed [15:0]        r_p;
    logic signed [16:0]        r_d;
    logic [DUTY_W-1:0]         r_duty;
    logic                      r_duty_valid;
    logic                      r_sat;
    logic [DUTY_W-1:0]         r_cnt;
    logic [DUTY_W-1:0]         r_active;
    logic                      r_pwm;

    logic signed [10:0]        w_e;
    logic signed [11:0]        w_de;
    logic signed [15:0]        w_kp_ext;
    logic signed [15:0]        w_e_ext;
    logic signed [15:0]        w_p;
    logic signed [16:0]        w_kd_ext;
    logic signed [16:0]        w_de_ext;
    logic signed [16:0]        w_d;
    logic signed [17:0]        w_sum;
    logic signed [17:0]        w_s;
    logic [DUTY_W-1:0]         w_clamp;
    logic                      w_clamp_sat;
    logic [DUTY_W-1:0]         w_duty_next;
    logic                      w_sat_next;

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_busy       = 1'b0;
        case (r_state)
            S_IDLE:    if (sample_en) w_state_next = S_CAPTURE;
            S_CAPTURE: begin w_busy = 1'b1; w_state_next = S_MULT; end
            S_MULT:    begin w_busy = 1'b1; w_state_next = S_SUM;  end
            S_SUM:     begin w_busy = 1'b1; w_state_next = S_IDLE; end
            default:   w_state_next = S_IDLE;
        endcase
    end

    // ---------------- arithmetic ----------------
    assign w_e      = $signed({1'b0, r_tgt}) - $signed({1'b0, r_cur});
    assign w_de     = $signed({w_e[10], w_e}) - $signed({r_prev[10], r_prev});
    // Gains are unsigned: zero-extend before the signed multiply.
    assign w_kp_ext = {12'd0, r_kp};
    assign w_e_ext  = {{5{r_e[10]}}, r_e};
    assign w_p      = w_kp_ext * w_e_ext;
    assign w_kd_ext = {13'd0, r_kd};
    assign w_de_ext = {{5{r_de[11]}}, r_de};
    assign w_d      = w_kd_ext * w_de_ext;
    assign w_sum    = {{2{r_p[15]}}, r_p} + {r_d[16], r_d};
    assign w_s      = w_sum >>> SHIFT;

    always_comb begin
        w_clamp     = w_s[DUTY_W-1:0];
        w_clamp_sat = 1'b0;
        if (w_s < 0) begin
            w_clamp     = '0;
            w_clamp_sat = 1'b1;
        end else if (w_s > c_duty_max) begin
            w_clamp     = {DUTY_W{1'b1}};
            w_clamp_sat = 1'b1;
        end
    end

`ifdef PD_SLEW_LIMIT_EN
    localparam logic [DUTY_W:0] c_step = (DUTY_W + 1)'(SLEW_STEP);

    always_comb begin : g_slew_limit
        w_duty_next = w_clamp;
        w_sat_next  = w_clamp_sat;
        if ({1'b0, w_clamp} > {1'b0, r_duty} + c_step) begin
            w_duty_next = r_duty + c_step[DUTY_W-1:0];
            w_sat_next  = 1'b1;
        end else if ({1'b0, w_clamp} + c_step < {1'b0, r_duty}) begin
            w_duty_next = r_duty - c_step[DUTY_W-1:0];
            w_sat_next  = 1'b1;
        end
    end
`else
    always_comb begin : g_no_slew
        w_duty_next = w_clamp;
        w_sat_next  = w_clamp_sat;
    end
`endif

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tgt        <= '0;
            r_cur        <= '0;
            r_kp         <= '0;
            r_kd         <= '0;
            r_e          <= '0;
            r_de         <= '0;
            r_prev       <= '0;
            r_p          <= '0;
            r_d          <= '0;
            r_duty       <= '0;
            r_duty_valid <= 1'b0;
            r_sat        <= 1'b0;
        end else begin
            r_duty_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (sample_en) begin
                        r_tgt <= target_vel;
                        r_cur <= current_vel;
                        r_kp  <= Kp;
                        r_kd  <= Kd;
                    end
                end
                S_CAPTURE: begin
                    r_e    <= w_e;
                    r_de   <= w_de;
                    r_prev <= w_e;
                end
                S_MULT: begin
                    r_p <= w_p;
                    r_d <= w_d;
                end
                S_SUM: begin
                    r_duty       <= w_duty_next;
                    r_sat        <= w_sat_next;
                    r_duty_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // ---------------- PWM: shadow duty loads only at the period boundary ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_active <= '0;
            r_pwm    <= 1'b0;
        end else begin
            r_cnt <= r_cnt + DUTY_W'(1);
            if (r_cnt == c_cnt_max) r_active <= r_duty;
            r_pwm <= (r_cnt < r_active);
        end
    end

    assign busy       = w_busy;
    assign duty       = r_duty;
    assign duty_valid = r_duty_valid;
    assign sat_flag   = r_sat;
    assign pwm_out    = r_pwm;

endmodule

`default_nettype wire

// File: tb/tb_pd_speed_regulator.sv
// ============================================================================
// Module   : tb_pd_speed_regulator
// Brief    : Scoreboard bench for pd_speed_regulator (honours PD_SLEW_LIMIT_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pd_speed_regulator;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sample_en;
    logic [9:0] target_vel;
    logic [9:0] current_vel;
    logic [3:0] Kp;
    logic [3:0] Kd;
    logic       busy;
    logic [7:0] duty;
    logic       duty_valid;
    logic       sat_flag;
    logic       pwm_out;

    pd_speed_regulator #(.DUTY_W(8), .SHIFT(2), .SLEW_STEP(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sample_en  (sample_en),
        .target_vel (target_vel),
        .current_vel(current_vel),
        .Kp         (Kp),
        .Kd         (Kd),
        .busy       (busy),
        .duty       (duty),
        .duty_valid (duty_valid),
        .sat_flag   (sat_flag),
        .pwm_out    (pwm_out)
    );

    always #5 clk = ~clk;

    // Hand-computed duty / sat for the seven accepted samples, in issue order.
`ifdef PD_SLEW_LIMIT_EN
    localparam int EXP_D [7] = '{8, 16, 8, 16, 24, 32, 8};
    localparam int EXP_S [7] = '{1, 1, 1, 1, 1, 1, 1};
`else
    localparam int EXP_D [7] = '{150, 100, 0, 255, 150, 100, 150};
    localparam int EXP_S [7] = '{0, 0, 1, 1, 0, 0, 0};
`endif

    typedef struct {
        int duty;
        int sat;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   checks   = 0;
    int   failures = 0;
    int   w;

    // Edge count since reset release; equals the DUT PWM counter modulo 256.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every duty_valid pops the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && duty_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_duty_valid: got duty=%0d expected no update", duty);
                end else begin
                    e = sb.pop_front();
                    check("duty", int'(duty), e.duty);
                    check("sat_flag", int'(sat_flag), e.sat);
                    check("latency", cyc - e.cyc, 3);
                end
            end
        end
    end

    // Issue one sample; returns the edge number at which duty is written.
    task automatic do_sample(input int idx, input logic [9:0] t, input logic [9:0] c,
                             input logic [3:0] p, input logic [3:0] d,
                             input bit extra, output int wr);
        exp_t e;
        target_vel  = t;
        current_vel = c;
        Kp          = p;
        Kd          = d;
        sample_en   = 1'b1;
        e.duty = EXP_D[idx];
        e.sat  = EXP_S[idx];
        e.cyc  = cyc + 1;
        sb.push_back(e);
        wr = cyc + 4;
        @(negedge clk);
        sample_en   = 1'b0;
        target_vel  = ~t;
        current_vel = ~c;
        Kp          = ~p;
        Kd          = ~d;
        check("busy", int'(busy), 1);
        @(negedge clk);
        if (extra) sample_en = 1'b1;
        @(negedge clk);
        sample_en = 1'b0;
        @(negedge clk);
    endtask

    // High count over one full period starting right after wrap edge L.
    task automatic pwm_window(input string name, input int L, input int exp);
        int hi;
        hi = 0;
        while (cyc < L + 1) @(negedge clk);
        for (int i = 0; i < 256; i++) begin
            hi += int'(pwm_out);
            @(negedge clk);
        end
        check(name, hi, exp);
    endtask

    task automatic align(input int ph);
        while (cyc % 256 != ph) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_duty"}, int'(duty), 0);
        check({tag, "_duty_valid"}, int'(duty_valid), 0);
        check({tag, "_sat_flag"}, int'(sat_flag), 0);
        check({tag, "_pwm_out"}, int'(pwm_out), 0);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        sample_en   = 1'b0;
        target_vel  = '0;
        current_vel = '0;
        Kp          = '0;
        Kd          = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        do_sample(0, 10'd600, 10'd500, 4'd4, 4'd2, 1'b0, w);
        do_sample(1, 10'd600, 10'd500, 4'd4, 4'd2, 1'b1, w);

        do_sample(2, 10'd100, 10'd600, 4'd8, 4'd0, 1'b0, w);
        pwm_window("pwm_low_clamp", (w / 256 + 1) * 256, EXP_D[2]);
        check("sat_held", int'(sat_flag), EXP_S[2]);

        do_sample(3, 10'd1023, 10'd0, 4'd15, 4'd15, 1'b0, w);
        pwm_window("pwm_high_clamp", (w / 256 + 1) * 256, EXP_D[3]);

        // Duty written two edges before the wrap: visible in the very next period.
        align(250);
        do_sample(4, 10'd650, 10'd500, 4'd4, 4'd0, 1'b0, w);
        pwm_window("pwm_pre_wrap", (w / 256 + 1) * 256, EXP_D[4]);

        // Duty written on the wrap edge: old duty for one more period.
        align(252);
        do_sample(5, 10'd600, 10'd500, 4'd4, 4'd0, 1'b0, w);
        pwm_window("pwm_on_wrap_old", w, EXP_D[4]);
        pwm_window("pwm_on_wrap_new", w + 256, EXP_D[5]);

        // Reset asserted mid-update: abort with no duty_valid.
        target_vel  = 10'd600;
        current_vel = 10'd500;
        Kp          = 4'd4;
        Kd          = 4'd2;
        sample_en   = 1'b1;
        @(negedge clk);
        sample_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("abort");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("abort_duty_after", int'(duty), 0);
        check("abort_sat_after", int'(sat_flag), 0);

        // prev_error was cleared, so the first sample repeats the reset result.
        do_sample(6, 10'd600, 10'd500, 4'd4, 4'd2, 1'b0, w);

        repeat (4) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
